fir_xifu_ctrl: RTL and testbench
================================

Name: fir_xifu_ctrl

Overview:
- Commit scoreboard and sequencer for the FIR XIFU pipeline.
- Tracks every instruction accepted by the ID stage, by XIF instruction id, until the core commits or kills it via the XIF commit interface.
- Gates the EX stage so that no memory request or XIFU register write happens before commit.
- Frees entries on retire and throttles issue when too many instructions are outstanding.

Parameters:
- ID_WIDTH, 4, width of XIF instruction id; scoreboard depth is 2**ID_WIDTH entries.
- MAX_OUTSTANDING, 4, maximum number of non-FREE entries (1..2**ID_WIDTH).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush of the whole scoreboard
- issue_i  in  1  ID stage accepted an instruction this cycle (valid_instr and ready)
- issue_id_i  in  ID_WIDTH  id of the accepted instruction
- issue_ready_o  out  1  scoreboard can take a new issue; ANDed into the XIF issue_ready
- commit_valid_i  in  1  XIF commit_valid
- commit_id_i  in  ID_WIDTH  XIF commit id
- commit_kill_i  in  1  XIF commit_kill
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_id_i  in  ID_WIDTH  id of the EX instruction
- ex_go_o  out  1  EX instruction is committed and may execute
- ex_kill_o  out  1  EX instruction is killed and must be dropped
- ex_ready_o  out  1  pipeline ready, fed back to the ID stage as ready_i
- retire_i  in  1  EX/WB finished an instruction
- retire_id_i  in  ID_WIDTH  id being retired
- outstanding_o  out  ID_WIDTH+1  number of non-FREE entries
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Each entry holds a 2-bit state: FREE=0, ISSUED=1, COMMITTED=2, KILLED=3.
- Reset and flush_i put every entry in FREE and set outstanding_o=0.
  - err_o clears on reset only; flush_i does not clear it.
  - flush_i has priority over all other same-cycle events.
- Issue: entry[issue_id_i] moves to ISSUED at the next edge.
  - If the entry is not FREE at issue, set err_o and still overwrite the entry to ISSUED.
  - Issuing while issue_ready_o=0 also sets err_o.
- Commit: an ISSUED entry moves to COMMITTED (kill=0) or KILLED (kill=1).
  - A commit on a FREE entry with no same-cycle issue of that id is ignored. The core commits non-accepted instructions too.
  - A commit on a COMMITTED or KILLED entry sets err_o; the state is unchanged.
- Same-cycle issue and commit of the same id: apply issue, then commit. The entry lands in COMMITTED or KILLED.
- Retire: a COMMITTED entry moves to FREE.
  - Retiring a FREE or ISSUED entry sets err_o; the state is unchanged.
  - Same-cycle retire of id X and issue of id X: issue wins, entry ends ISSUED, no error.
- EX gating is combinational, with commit bypass:
  - ex_go_o = ex_valid_i & (state==COMMITTED | (commit_valid_i & commit_id_i==ex_id_i & !commit_kill_i & state==ISSUED)).
  - ex_kill_o = the same expression with KILLED and commit_kill_i=1.
  - ex_ready_o = !ex_valid_i | ex_go_o | ex_kill_o, i.e. the pipeline stalls while the EX instruction is waiting for commit.
- When ex_kill_o=1, the scoreboard frees that entry itself at the next edge; EX must not retire it.
- issue_ready_o = (outstanding_o < MAX_OUTSTANDING), registered-count based.
  - An entry freed this cycle counts as free from the next cycle only.
- outstanding_o is the registered count. Each cycle it updates as +issue −retire −kill, saturating and never wrapping.
- Latency:
  - Issue → visible in state after 1 cycle.
  - Commit → ex_go_o in the same cycle via the bypass.
  - Retire → issue_ready_o rises after 1 cycle.

Test Plan:
- Reset with all inputs 0 → outstanding_o=0, issue_ready_o=1, ex_go_o=0, ex_kill_o=0, ex_ready_o=1, err_o=0.
- Issue id 3; EX valid with id 3 for 2 cycles with no commit → ex_ready_o=0 both cycles. Then commit id 3 with kill=0 → ex_go_o=1 in the commit cycle. Retire id 3 → outstanding_o returns 0.
- Issue ids 0,1,2,3 back-to-back with MAX_OUTSTANDING=4 → issue_ready_o=0 after the 4th. Retire id 0 (committed) → issue_ready_o=1 one cycle later.
- Issue id 5 and commit id 5 with kill=1 in the same cycle; EX valid with id 5 the next cycle → ex_kill_o=1, ex_ready_o=1. Entry becomes FREE and outstanding_o drops 1→0.
- Commit id 9 (never issued) → no state change, err_o=0. Issue id 2 twice without retire → err_o=1 and stays 1 after a flush.
- Issue ids 1,2, then flush_i=1 in the same cycle as commit id 1 → all entries FREE, outstanding_o=0, ex_go_o=0 for id 1 afterwards.

Source files
------------

// File: rtl/fir_xifu_ctrl.sv
// Commit scoreboard for the FIR XIFU pipeline: tracks each XIF instruction id from
// issue to retire and holds EX until the core has committed or killed the instruction.
//
// state        | meaning
// ST_FREE      | id not in flight
// ST_ISSUED    | accepted by ID, waiting for XIF commit
// ST_COMMITTED | committed, EX may execute; freed by retire
// ST_KILLED    | killed by the core; freed when EX drops it
module fir_xifu_ctrl #(
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                issue_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   output logic                issue_ready_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   input  logic                ex_valid_i,
   input  logic [ID_WIDTH-1:0] ex_id_i,
   output logic                ex_go_o,
   output logic                ex_kill_o,
   output logic                ex_ready_o,
   input  logic                retire_i,
   input  logic [ID_WIDTH-1:0] retire_id_i,
   output logic [ID_WIDTH:0]   outstanding_o,
   output logic                err_o
);

   localparam int DEPTH = 2 ** ID_WIDTH;
   localparam int CW    = ID_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_ISSUED    = 2'd1,
      ST_COMMITTED = 2'd2,
      ST_KILLED    = 2'd3
   } entry_state_e;

   entry_state_e   st_q [DEPTH];
   entry_state_e   st_d [DEPTH];
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   entry_state_e   ex_st;
   logic           ex_byp;
   logic           retire_ok;
   logic           same_ic;

   // Commit bypass lets EX proceed in the very cycle the core commits.
   assign ex_st      = st_q[ex_id_i];
   assign ex_byp     = commit_valid_i && (commit_id_i == ex_id_i) && (ex_st == ST_ISSUED);
   assign ex_go_o    = ex_valid_i && ((ex_st == ST_COMMITTED) || (ex_byp && !commit_kill_i));
   assign ex_kill_o  = ex_valid_i && ((ex_st == ST_KILLED) || (ex_byp && commit_kill_i));
   assign ex_ready_o = !ex_valid_i || ex_go_o || ex_kill_o;

   assign issue_ready_o = (cnt_q < CW'(MAX_OUTSTANDING));
   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

   assign retire_ok = retire_i && (st_q[retire_id_i] == ST_COMMITTED);
   assign same_ic   = issue_i && commit_valid_i && (issue_id_i == commit_id_i);

   always_comb begin
      st_d  = st_q;
      err_d = err_q;
      cnt_d = '0;

      if (retire_i) begin
         if (retire_ok) st_d[retire_id_i] = ST_FREE;
         else           err_d = 1'b1;
      end

      if (commit_valid_i && !same_ic) begin
         case (st_q[commit_id_i])
            ST_ISSUED:    st_d[commit_id_i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
            ST_COMMITTED,
            ST_KILLED:    err_d = 1'b1;
            default:      ;
         endcase
      end

      if (ex_kill_o) st_d[ex_id_i] = ST_FREE;

      // Issue overrides a same-cycle retire or kill-free of the same id.
      if (issue_i) begin
         if (!issue_ready_o) err_d = 1'b1;
         if ((st_q[issue_id_i] != ST_FREE)
             && !(retire_ok && (retire_id_i == issue_id_i))
             && !(ex_kill_o && (ex_id_i == issue_id_i)))
            err_d = 1'b1;
         if (same_ic) st_d[issue_id_i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
         else         st_d[issue_id_i] = ST_ISSUED;
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (st_d[i] != ST_FREE) cnt_d = cnt_d + CW'(1);
      end

      if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) st_d[i] = ST_FREE;
         err_d = err_q;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_FREE;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Directed, table-driven bench for fir_xifu_ctrl: one record per clock cycle holding
// the inputs driven in that cycle and the outputs expected before its closing edge.
module tb_fir_xifu_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       flush_i = 1'b0;
   logic       issue_i = 1'b0;
   logic [3:0] issue_id_i = '0;
   logic       issue_ready_o;
   logic       commit_valid_i = 1'b0;
   logic [3:0] commit_id_i = '0;
   logic       commit_kill_i = 1'b0;
   logic       ex_valid_i = 1'b0;
   logic [3:0] ex_id_i = '0;
   logic       ex_go_o, ex_kill_o, ex_ready_o;
   logic       retire_i = 1'b0;
   logic [3:0] retire_id_i = '0;
   logic [4:0] outstanding_o;
   logic       err_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   fir_xifu_ctrl #(.ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .issue_i        (issue_i),
      .issue_id_i     (issue_id_i),
      .issue_ready_o  (issue_ready_o),
      .commit_valid_i (commit_valid_i),
      .commit_id_i    (commit_id_i),
      .commit_kill_i  (commit_kill_i),
      .ex_valid_i     (ex_valid_i),
      .ex_id_i        (ex_id_i),
      .ex_go_o        (ex_go_o),
      .ex_kill_o      (ex_kill_o),
      .ex_ready_o     (ex_ready_o),
      .retire_i       (retire_i),
      .retire_id_i    (retire_id_i),
      .outstanding_o  (outstanding_o),
      .err_o          (err_o)
   );

   typedef struct packed {
      logic       flush;
      logic       iss;
      logic [3:0] iid;
      logic       cv;
      logic [3:0] cid;
      logic       ck;
      logic       exv;
      logic [3:0] exid;
      logic       ret;
      logic [3:0] rid;
      logic       go;
      logic       kill;
      logic       rdy;
      logic       ir;
      logic [4:0] outs;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   row = 0;

   function automatic vec_t mk(input logic fl, input logic is, input logic [3:0] iid,
                               input logic cv, input logic [3:0] cid, input logic ck,
                               input logic exv, input logic [3:0] exid,
                               input logic rt, input logic [3:0] rid,
                               input logic go, input logic kl, input logic rdy,
                               input logic ir, input logic [4:0] outs, input logic er);
      vec_t v;
      v = '{flush: fl, iss: is, iid: iid, cv: cv, cid: cid, ck: ck, exv: exv, exid: exid,
            ret: rt, rid: rid, go: go, kill: kl, rdy: rdy, ir: ir, outs: outs, err: er};
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
      end
   endtask

   // Called just after a rising edge: drive, check at the falling edge, cross the next edge.
   task automatic run_vec(input vec_t v);
      flush_i        = v.flush;
      issue_i        = v.iss;
      issue_id_i     = v.iid;
      commit_valid_i = v.cv;
      commit_id_i    = v.cid;
      commit_kill_i  = v.ck;
      ex_valid_i     = v.exv;
      ex_id_i        = v.exid;
      retire_i       = v.ret;
      retire_id_i    = v.rid;
      @(negedge clk_i);
      check("ex_go",         int'(ex_go_o),       int'(v.go));
      check("ex_kill",       int'(ex_kill_o),     int'(v.kill));
      check("ex_ready",      int'(ex_ready_o),    int'(v.rdy));
      check("issue_ready",   int'(issue_ready_o), int'(v.ir));
      check("outstanding",   int'(outstanding_o), int'(v.outs));
      check("err",           int'(err_o),         int'(v.err));
      @(posedge clk_i);
      #1;
      row++;
   endtask

   task automatic do_reset();
      flush_i = 0; issue_i = 0; commit_valid_i = 0; commit_kill_i = 0;
      ex_valid_i = 0; retire_i = 0;
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      //                fl is iid cv cid ck exv exid rt rid  go kl rdy ir outs err
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0)); // reset state
      vecs.push_back(mk(0, 1, 3,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  3,   0, 0,   0, 0, 0,  1, 1,   0)); // waiting for commit
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  3,   0, 0,   0, 0, 0,  1, 1,   0));
      vecs.push_back(mk(0, 0, 0,  1, 3,  0, 1,  3,   0, 0,   1, 0, 1,  1, 1,   0)); // commit bypass
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   1, 3,   0, 0, 1,  1, 1,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0));
      vecs.push_back(mk(0, 1, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0)); // fill to limit
      vecs.push_back(mk(0, 1, 1,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 1,   0));
      vecs.push_back(mk(0, 1, 2,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 2,   0));
      vecs.push_back(mk(0, 1, 3,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 3,   0));
      vecs.push_back(mk(0, 0, 0,  1, 0,  0, 0,  0,   0, 0,   0, 0, 1,  0, 4,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   1, 0,   0, 0, 1,  0, 4,   0)); // freed next cycle
      vecs.push_back(mk(0, 0, 0,  1, 1,  0, 0,  0,   0, 0,   0, 0, 1,  1, 3,   0));
      vecs.push_back(mk(0, 0, 0,  1, 2,  0, 0,  0,   1, 1,   0, 0, 1,  1, 3,   0));
      vecs.push_back(mk(0, 0, 0,  1, 3,  0, 0,  0,   1, 2,   0, 0, 1,  1, 2,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   1, 3,   0, 0, 1,  1, 1,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0));
      vecs.push_back(mk(0, 1, 5,  1, 5,  1, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0)); // issue+kill
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  5,   0, 0,   0, 1, 1,  1, 1,   0));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 1,  5,   0, 0,   0, 0, 0,  1, 0,   0)); // entry freed
      vecs.push_back(mk(0, 0, 0,  1, 9,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0)); // stray commit
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0));
      vecs.push_back(mk(0, 1, 2,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   0));
      vecs.push_back(mk(0, 1, 2,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 1,   0)); // double issue
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 1,   1));
      vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 1,   1));
      vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0,   0, 0,   0, 0, 1,  1, 0,   1)); // err sticky

      do_reset();
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      // Flush in the same cycle as a commit
      run_vec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1));
      run_vec(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 1));
      run_vec(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2, 1));
      run_vec(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1, 0, 1));

      // Retire and re-issue of one id, then a commit on a committed entry
      do_reset();
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0));
      run_vec(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0));
      run_vec(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0));
      run_vec(mk(0, 1, 7, 0, 0, 0, 0, 0, 1, 7,  0, 0, 1, 1, 1, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 0, 1, 1, 0));
      run_vec(mk(0, 0, 0, 1, 7, 0, 1, 7, 0, 0,  1, 0, 1, 1, 1, 0));
      run_vec(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 1));

      // Issue while not ready
      do_reset();
      run_vec(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0));
      run_vec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0));
      run_vec(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 2, 0));
      run_vec(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 3, 0));
      run_vec(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 4, 0));
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 5, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
